// File: rtl/tdm_demux8_pkg.sv
// Shared definitions for the TDM demux and the tx-side mux.
// FSM encodings and default frame geometry.
package tdm_demux8_pkg;
  localparam int N_CH_DEF  = 8;
  localparam int SEL_W_DEF = 3;
  localparam int WIDTH_DEF = 1;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
endpackage

// File: rtl/tdm_demux8_slot_counter.sv
// Mod-N_CH slot counter.
// Priority when several controls are high: clear, then load-to-1, then increment.
module slot_counter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [SEL_W-1:0] cnt
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (load1)    cnt <= SEL_W'(1);
    else if (en)       cnt <= (cnt == LAST) ? '0 : cnt + SEL_W'(1);
  end
endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the 8:1 TDM link.
// Slots are collected in a shadow register; a complete frame is published to dout in a single cycle.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [N_CH*WIDTH-1:0] dout,
  output logic                  frame_valid,
  output logic [SEL_W-1:0]      sel,
  output logic                  locked,
  output logic                  sync_err
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  logic [0:0]                  state;
  logic [SEL_W-1:0]            slot;
  logic [N_CH-1:0][WIDTH-1:0]  shadow;
  logic                        start, early, missing, store, last;

  // In LOCKED, a beat that is neither an early nor a missing sync is a normal store.
  always_comb begin
    start   = din_valid && (state == ST_HUNT) && frame_sync;
    early   = din_valid && (state == ST_LOCKED) && frame_sync && (slot != '0);
    missing = din_valid && (state == ST_LOCKED) && !frame_sync && (slot == '0);
    store   = din_valid && (state == ST_LOCKED) && !early && !missing;
    last    = store && (slot == LAST);
  end

  slot_counter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (missing),
    .load1 (start || early),
    .en    (store),
    .cnt   (slot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= last;
      sync_err    <= early || missing;
      if (start || early) shadow[0] <= din;
      else if (store)     shadow[slot] <= din;
      if (last) dout <= {din, shadow[N_CH-2:0]};
      if (start)        state <= ST_LOCKED;
      else if (missing) state <= ST_HUNT;
    end
  end

  assign sel    = slot;
  assign locked = (state == ST_LOCKED);
endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized + directed bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:0]   din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [N-1:0] dout;
  logic         frame_valid;
  logic [2:0]   sel;
  logic         locked;
  logic         sync_err;

  int vectors = 0;
  int miscompares = 0;

  tdm_demux8 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .frame_valid(frame_valid),
    .sel(sel), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Model: a frame is a list of received slots; it is published when it reaches N entries.
  bit           m_started = 0;
  bit           m_locked;
  bit           q[$];
  logic [N-1:0] m_dout;
  bit           m_fv, m_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 1;
      m_locked = 0; q.delete(); m_dout = '0; m_fv = 0; m_err = 0;
    end else begin
      m_fv = 0; m_err = 0;
      if (din_valid) begin
        if (!m_locked) begin
          if (frame_sync) begin q.delete(); q.push_back(din[0]); m_locked = 1; end
        end else if (frame_sync) begin
          if (q.size() != 0) m_err = 1;
          q.delete(); q.push_back(din[0]);
        end else if (q.size() == 0) begin
          m_err = 1; m_locked = 0;
        end else begin
          q.push_back(din[0]);
          if (q.size() == N) begin
            for (int i = 0; i < N; i++) m_dout[i] = q[i];
            m_fv = 1; q.delete();
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus frame_valid bookkeeping.
  int cyc = 0;
  int fv_total = 0;
  int fv_cycles[$];
  always @(negedge clk) begin
    cyc++;
    if (m_started) begin
      check("dout", 32'(dout), 32'(m_dout));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("sync_err", 32'(sync_err), 32'(m_err));
      check("sel", 32'(sel), 32'(q.size()));
      check("locked", 32'(locked), 32'(m_locked));
      check("err_fv_exclusive", 32'(sync_err && frame_valid), 32'(0));
      if (frame_valid) begin fv_total++; fv_cycles.push_back(cyc); end
    end
  end

  task automatic beat(input bit d, input bit s);
    din = d; frame_sync = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] f, input int gap);
    for (int i = 0; i < N; i++) begin
      beat(f[i], i == 0);
      if (gap > 0 && i != N-1) idle(gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int fv0;
    logic [2:0] s_hold;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic frame
    fv0 = fv_total;
    send_frame(8'b0100_1101, 0);
    check("t1_dout", 32'(dout), 32'h4D);
    check("t1_fv", 32'(frame_valid), 32'h1);
    idle(2);
    check("t1_fv_count", 32'(fv_total - fv0), 32'h1);

    // 2: same frame with gaps; sel holds across idle cycles
    fv0 = fv_total;
    beat(1'b1, 1'b1);
    s_hold = sel;
    idle(3);
    check("t2_sel_hold", 32'(sel), 32'(s_hold));
    beat(1'b0, 1'b0); idle(3);
    beat(1'b1, 1'b0); idle(3);
    beat(1'b1, 1'b0); idle(3);
    beat(1'b0, 1'b0); idle(3);
    beat(1'b0, 1'b0); idle(3);
    beat(1'b1, 1'b0); idle(3);
    beat(1'b0, 1'b0);
    check("t2_dout", 32'(dout), 32'h4D);
    idle(1);
    check("t2_fv_count", 32'(fv_total - fv0), 32'h1);

    // 3: early sync on the 4th beat
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    check("t3_sync_err", 32'(sync_err), 32'h1);
    check("t3_dout_kept", 32'(dout), 32'h4D);
    check("t3_sel", 32'(sel), 32'h1);
    for (int i = 1; i < N; i++) beat(i[0], 1'b0);
    check("t3_new_frame", 32'(dout), 32'hAB);
    check("t3_fv", 32'(frame_valid), 32'h1);

    // 4: 9th beat without sync drops lock; later beats ignored
    beat(1'b1, 1'b0);
    check("t4_sync_err", 32'(sync_err), 32'h1);
    check("t4_locked", 32'(locked), 32'h0);
    beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    check("t4_still_hunt", 32'(locked), 32'h0);
    check("t4_sel", 32'(sel), 32'h0);

    // 5: reset mid-frame
    beat(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    check("t5_dout", 32'(dout), 32'h0);
    check("t5_sel", 32'(sel), 32'h0);
    check("t5_locked", 32'(locked), 32'h0);
    fv0 = fv_total;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    idle(1);
    check("t5_no_fv", 32'(fv_total - fv0), 32'h0);
    for (int i = 3; i < N; i++) beat(1'b0, 1'b0);
    check("t5_recover", 32'(dout), 32'h05);

    // 6: two back-to-back frames
    idle(2);
    fv0 = fv_total;
    fv_cycles.delete();
    send_frame(8'h3C, 0);
    send_frame(8'hC3, 0);
    idle(2);
    check("t6_fv_count", 32'(fv_total - fv0), 32'h2);
    if (fv_cycles.size() == 2)
      check("t6_fv_spacing", 32'(fv_cycles[1] - fv_cycles[0]), 32'h8);
    else
      check("t6_fv_spacing_n", 32'(fv_cycles.size()), 32'h2);
    check("t6_dout", 32'(dout), 32'hC3);

    // Random phase: mostly well-formed framing, occasional sync faults and gaps
    for (int n = 0; n < 3000; n++) begin
      bit s;
      bit want;
      want = !m_locked || (q.size() == 0);
      s = ($urandom_range(0, 15) == 0) ? bit'($urandom_range(0, 1)) : want;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
      end
      beat(bit'($urandom_range(0, 1)), s);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
